// File: rtl/bs_digit_packer.sv
// Digit-serial to parallel packer: collects signed digits MSD-first into a
// W-digit borrow-save word and holds it for the downstream converter.
module bs_digit_packer #(
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   d_valid,
  output logic                   d_ready,
  input  logic [1:0]             d_digit,
  input  logic                   d_last,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [2*W-1:0]         y,
  output logic [$clog2(W+1)-1:0] y_ndig
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int NW = $clog2(W + 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [KW-1:0]   k;
  logic [KW-1:0]   pos;
  logic [2*W-1:0]  dbuf;
  logic [2*W-1:0]  dbuf_ins;
  logic            dig_acc;
  logic            word_done;
  logic            word_xfer;

  // The redundant pair 11 carries value zero; fold it to 00 so y stays canonical.
  function automatic logic [1:0] norm_digit(input logic [1:0] dg);
    return (dg == 2'b11) ? 2'b00 : dg;
  endfunction

  // State register; reset wins over any handshake in flight.
  always_ff @(posedge clk) begin
    if (srst) state <= ACC;
    else      state <= state_nxt;
  end

  // Next-state and handshake decode; d_ready depends only on state and srst.
  always_comb begin
    state_nxt = state;
    d_ready   = 1'b0;
    y_valid   = 1'b0;
    case (state)
      ACC: begin
        d_ready = !srst;
        if (d_valid && (d_last || (k == KW'(W - 1)))) state_nxt = HOLD;
      end
      HOLD: begin
        y_valid = 1'b1;
        if (y_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  assign dig_acc   = d_valid && d_ready;
  assign word_done = dig_acc && (d_last || (k == KW'(W - 1)));
  assign word_xfer = (state == HOLD) && y_ready;
  assign pos       = KW'(W - 1) - k;

  // Buffer with the incoming digit dropped into its MSD-first slot.
  always_comb begin
    dbuf_ins = dbuf;
    dbuf_ins[{pos, 1'b0} +: 2] = norm_digit(d_digit);
  end

  // Digit counter, assembly buffer and the held output word.
  always_ff @(posedge clk) begin
    if (srst) begin
      k      <= '0;
      dbuf   <= '0;
      y      <= '0;
      y_ndig <= '0;
    end else if (word_xfer) begin
      k      <= '0;
      dbuf   <= '0;
      y      <= '0;
      y_ndig <= '0;
    end else if (dig_acc) begin
      dbuf <= dbuf_ins;
      if (word_done) begin
        y      <= dbuf_ins;
        y_ndig <= NW'(k) + NW'(1);
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bs_digit_packer.sv
// Directed and randomised checks of bs_digit_packer at W=4 and W=64.
module tb_bs_digit_packer;

  logic clk = 1'b0;
  logic srst;

  // W=4 instance
  logic       d_valid4, d_ready4, d_last4, y_valid4, y_ready4;
  logic [1:0] d_digit4;
  logic [7:0] y4;
  logic [2:0] y_ndig4;

  // W=64 instance
  logic         r_d_valid, r_d_ready, r_d_last, r_y_valid, r_y_ready;
  logic [1:0]   r_d_digit;
  logic [127:0] r_y;
  logic [6:0]   r_y_ndig;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bs_digit_packer #(.W(4)) u4 (
    .clk(clk), .srst(srst), .d_valid(d_valid4), .d_ready(d_ready4),
    .d_digit(d_digit4), .d_last(d_last4), .y_valid(y_valid4),
    .y_ready(y_ready4), .y(y4), .y_ndig(y_ndig4)
  );

  bs_digit_packer #(.W(64)) u64 (
    .clk(clk), .srst(srst), .d_valid(r_d_valid), .d_ready(r_d_ready),
    .d_digit(r_d_digit), .d_last(r_d_last), .y_valid(r_y_valid),
    .y_ready(r_y_ready), .y(r_y), .y_ndig(r_y_ndig)
  );

  typedef struct {
    logic [7:0] digs;   // first digit in bits 7:6
    int         n;
    logic       lst;
    logic [7:0] y_exp;
    logic [2:0] nd_exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   tmp;
    logic [127:0] exp_y;
    logic [63:0]  sum, conv, dp, sp;
    logic [1:0]   dg;
    int           n, hold_cycles;
    logic         use_last, was_ready;

    vecs[0] = '{8'b01_00_10_01, 4, 1'b0, 8'b01_00_10_01, 3'd4};
    vecs[1] = '{8'b01_10_00_00, 2, 1'b1, 8'b01_10_00_00, 3'd2};
    vecs[2] = '{8'b11_11_11_11, 4, 1'b0, 8'b00_00_00_00, 3'd4};
    vecs[3] = '{8'b10_10_10_00, 3, 1'b1, 8'b10_10_10_00, 3'd3};
    vecs[4] = '{8'b01_00_00_00, 1, 1'b1, 8'b01_00_00_00, 3'd1};
    vecs[5] = '{8'b01_01_01_10, 4, 1'b1, 8'b01_01_01_10, 3'd4};
    vecs[6] = '{8'b11_01_11_00, 3, 1'b1, 8'b00_01_00_00, 3'd3};

    srst = 1'b1;
    d_valid4 = 1'b1; d_digit4 = 2'b01; d_last4 = 1'b0; y_ready4 = 1'b1;
    r_d_valid = 1'b0; r_d_digit = 2'b00; r_d_last = 1'b0; r_y_ready = 1'b1;
    step();
    step();
    check("rst_d_ready", 128'(d_ready4), 128'(0));
    check("rst_y_valid", 128'(y_valid4), 128'(0));
    check("rst_y", 128'(y4), 128'(0));
    check("rst_y_ndig", 128'(y_ndig4), 128'(0));
    srst = 1'b0;
    d_valid4 = 1'b0;
    step();
    check("post_rst_d_ready", 128'(d_ready4), 128'(1));
    check("post_rst_y_valid", 128'(y_valid4), 128'(0));

    // table-driven words, downstream always ready
    for (int v = 0; v < 7; v++) begin
      tmp = vecs[v].digs;
      y_ready4 = 1'b1;
      for (int j = 0; j < vecs[v].n; j++) begin
        check($sformatf("v%0d_ready_d%0d", v, j), 128'({d_ready4, y_valid4}), 128'(2'b10));
        d_valid4 = 1'b1;
        d_digit4 = tmp[7-2*j -: 2];
        d_last4  = (j == vecs[v].n - 1) && vecs[v].lst;
        step();
      end
      d_valid4 = 1'b0;
      d_last4  = 1'b0;
      check($sformatf("v%0d_y_valid", v), 128'(y_valid4), 128'(1));
      check($sformatf("v%0d_y", v), 128'(y4), 128'(vecs[v].y_exp));
      check($sformatf("v%0d_y_ndig", v), 128'(y_ndig4), 128'(vecs[v].nd_exp));
      check($sformatf("v%0d_d_ready_hold", v), 128'(d_ready4), 128'(0));
      step();
      check($sformatf("v%0d_pulse_end", v), 128'({y_valid4, d_ready4}), 128'(2'b01));
      check($sformatf("v%0d_y_cleared", v), 128'({y4, y_ndig4}), 128'(0));
    end

    // backpressure: word held while upstream keeps offering digits
    y_ready4 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      d_valid4 = 1'b1;
      d_digit4 = (j < 2) ? 2'b01 : 2'b00;
      d_last4  = 1'b0;
      step();
    end
    check("bp_y_valid", 128'(y_valid4), 128'(1));
    check("bp_y", 128'(y4), 128'(8'b01_01_00_00));
    for (int c = 0; c < 5; c++) begin
      d_valid4 = 1'b1;
      d_digit4 = 2'(c + 1);
      d_last4  = c[0];
      step();
      check($sformatf("bp_hold%0d_y", c), 128'(y4), 128'(8'b01_01_00_00));
      check($sformatf("bp_hold%0d_ndig", c), 128'(y_ndig4), 128'(4));
      check($sformatf("bp_hold%0d_hs", c), 128'({d_ready4, y_valid4}), 128'(2'b01));
    end
    y_ready4 = 1'b1;
    d_valid4 = 1'b0;
    d_last4  = 1'b0;
    step();
    check("bp_release", 128'({d_ready4, y_valid4}), 128'(2'b10));
    // d_last without d_valid must not end a word
    d_last4  = 1'b1;
    d_digit4 = 2'b01;
    step();
    check("bp_lone_last", 128'(y_valid4), 128'(0));
    d_valid4 = 1'b1;
    d_digit4 = 2'b10;
    d_last4  = 1'b1;
    step();
    d_valid4 = 1'b0;
    d_last4  = 1'b0;
    check("bp_next_y", 128'(y4), 128'(8'b10_00_00_00));
    check("bp_next_ndig", 128'(y_ndig4), 128'(1));
    step();

    // reset mid-word discards partial digits
    d_valid4 = 1'b1; d_digit4 = 2'b01; d_last4 = 1'b0;
    step();
    d_digit4 = 2'b10;
    step();
    srst = 1'b1;
    d_digit4 = 2'b10;
    #1;
    check("mid_rst_d_ready", 128'(d_ready4), 128'(0));
    step();
    srst = 1'b0;
    check("mid_rst_state", 128'({y_valid4, y4, y_ndig4}), 128'(0));
    for (int j = 0; j < 4; j++) begin
      d_valid4 = 1'b1;
      d_digit4 = 2'b01;
      d_last4  = 1'b0;
      step();
    end
    d_valid4 = 1'b0;
    check("mid_rst_y_valid", 128'(y_valid4), 128'(1));
    check("mid_rst_y", 128'(y4), 128'(8'b01_01_01_01));
    check("mid_rst_ndig", 128'(y_ndig4), 128'(4));
    step();

    // W=64 random words with random gaps, d_last and backpressure
    for (int w = 0; w < 100; w++) begin
      n        = $urandom_range(1, 64);
      use_last = (n < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_y    = '0;
      sum      = '0;
      for (int j = 0; j < n; j++) begin
        while ($urandom_range(0, 3) == 0) begin
          r_d_valid = 1'b0;
          r_d_last  = 1'($urandom_range(0, 1));
          r_d_digit = 2'($urandom_range(0, 3));
          r_y_ready = 1'($urandom_range(0, 1));
          step();
        end
        dg = 2'($urandom_range(0, 3));
        r_d_valid = 1'b1;
        r_d_digit = dg;
        r_d_last  = (j == n - 1) && use_last;
        r_y_ready = 1'($urandom_range(0, 1));
        if (dg == 2'b01) begin
          exp_y[2*(63-j) +: 2] = 2'b01;
          sum = sum + (64'd1 << (63 - j));
        end else if (dg == 2'b10) begin
          exp_y[2*(63-j) +: 2] = 2'b10;
          sum = sum - (64'd1 << (63 - j));
        end
        step();
      end
      r_d_valid = 1'b1;
      r_d_last  = 1'b1;
      r_d_digit = 2'b01;
      for (int c = 0; c < 4 && !r_y_valid; c++) step();
      check($sformatf("w%0d_y_valid", w), 128'(r_y_valid), 128'(1));
      check($sformatf("w%0d_y", w), r_y, exp_y);
      check($sformatf("w%0d_ndig", w), 128'(r_y_ndig), 128'(n));
      dp = '0;
      sp = '0;
      for (int i = 0; i < 64; i++) begin
        dp[i] = r_y[2*i];
        sp[i] = r_y[2*i+1];
      end
      conv = dp - sp;
      check($sformatf("w%0d_conv", w), 128'(conv), 128'(sum));
      hold_cycles = 0;
      was_ready   = 1'b0;
      while (!was_ready) begin
        r_y_ready = (hold_cycles >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        r_d_digit = 2'($urandom_range(0, 3));
        was_ready = r_y_ready;
        if (hold_cycles > 0)
          check($sformatf("w%0d_hold_y", w), r_y, exp_y);
        step();
        hold_cycles++;
      end
      r_d_valid = 1'b0;
      r_d_last  = 1'b0;
      check($sformatf("w%0d_xfer", w), 128'({r_y_valid, r_d_ready}), 128'(2'b01));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
